// File: rtl/rot_pkg.sv
// Shared types for the image-rotation tile address generator:
// FSM state encoding, quarter-turn encodings and the effective
// clockwise-turn helper.
package rot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DEG_0   = 2'd0,
        DEG_90  = 2'd1,
        DEG_180 = 2'd2,
        DEG_270 = 2'd3
    } deg_e;

    // Counter-clockwise n quarter turns equals clockwise (4-n) mod 4;
    // the 2-bit wrap of the subtraction provides the mod 4.
    function automatic deg_e cw_turns(input logic direction, input logic [1:0] degrees);
        logic [1:0] turns;
        turns = direction ? degrees : 2'(2'd0 - degrees);
        return deg_e'(turns);
    endfunction

endpackage

// File: rtl/rot_tile_addr_gen_if.sv
// DMA beat channel between the tile address generator (master) and the
// DMA engine (slave): address, direction, tile-buffer index and handshake.
interface rot_tile_addr_gen_if #(
    parameter int ADDR_W    = 32,
    parameter int TILE_LOG2 = 3
);
    logic [ADDR_W-1:0]      O_ADDR;
    logic                   O_VALID;
    logic                   O_WRITE;
    logic [2*TILE_LOG2-1:0] O_COUNT;
    logic                   I_DMA_READY;

    modport master (
        output O_ADDR,
        output O_VALID,
        output O_WRITE,
        output O_COUNT,
        input  I_DMA_READY
    );

    modport slave (
        input  O_ADDR,
        input  O_VALID,
        input  O_WRITE,
        input  O_COUNT,
        output I_DMA_READY
    );
endinterface

// File: rtl/rot_coord_map.sv
// Combinational source-to-destination pixel mapping: optional horizontal
// mirror, then q clockwise quarter turns over the padded PH x PW image.
// Mirror logic is only built when ROT_MIRROR_EN is defined.
module rot_coord_map
    import rot_pkg::*;
#(
    parameter int DIM_W = 15
) (
    input  logic [DIM_W:0] y,
    input  logic [DIM_W:0] x,
    input  deg_e           q,
    input  logic           mirror,
    input  logic [DIM_W:0] ph,
    input  logic [DIM_W:0] pw,
    output logic [DIM_W:0] dy,
    output logic [DIM_W:0] dx,
    output logic [DIM_W:0] dw
);

    localparam logic [DIM_W:0] ONE = 1;

    logic [DIM_W:0] xm;
    logic [DIM_W:0] y_flip;
    logic [DIM_W:0] x_flip;

`ifdef ROT_MIRROR_EN
    assign xm = mirror ? (pw - ONE - x) : x;
`else
    logic unused_mirror;
    assign unused_mirror = mirror;
    assign xm            = x;
`endif

    assign y_flip = ph - ONE - y;
    assign x_flip = pw - ONE - xm;

    // Select destination coordinates and row pitch for the turn count.
    always_comb begin
        dy = y;
        dx = xm;
        dw = pw;
        case (q)
            DEG_0:   begin dy = y;      dx = xm;     dw = pw; end
            DEG_90:  begin dy = xm;     dx = y_flip; dw = ph; end
            DEG_180: begin dy = y_flip; dx = x_flip; dw = pw; end
            DEG_270: begin dy = x_flip; dx = y;      dw = ph; end
            default: begin dy = y;      dx = xm;     dw = pw; end
        endcase
    end

endmodule

// File: rtl/rot_tile_addr_gen.sv
// Tile address generator for the image-rotation core. Walks the padded
// source image tile by tile, issuing T*T read beats then T*T write beats
// per tile to the rotated (optionally mirrored) destination.
// Optional feature macro: ROT_MIRROR_EN (horizontal mirror before rotation).
module rot_tile_addr_gen
    import rot_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DIM_W     = 15,
    parameter int TILE_LOG2 = 3,
    parameter int BPP       = 3
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET,
    input  logic              I_START,
    input  logic [DIM_W-1:0]  I_HEIGHT,
    input  logic [DIM_W-1:0]  I_WIDTH,
    input  logic [ADDR_W-1:0] I_SRC_BASE,
    input  logic [ADDR_W-1:0] I_DST_BASE,
    input  logic              I_DIRECTION,
    input  logic [1:0]        I_DEGREES,
    input  logic              I_MIRROR,
    rot_tile_addr_gen_if.master dma,
    output logic              O_BUSY,
    output logic              O_DONE
);

    localparam int T  = 1 << TILE_LOG2;
    localparam int TW = DIM_W + 1 - TILE_LOG2;
    localparam logic [TILE_LOG2-1:0] T_LAST   = '1;
    localparam logic [DIM_W:0]       PAD_ADD  = (DIM_W + 1)'(T - 1);
    localparam logic [DIM_W:0]       PAD_MASK = ~PAD_ADD;

    state_e                 state_reg, state_next;
    logic [TW-1:0]          ty_reg, ty_next;
    logic [TW-1:0]          tx_reg, tx_next;
    logic [TILE_LOG2-1:0]   r_reg, r_next;
    logic [TILE_LOG2-1:0]   c_reg, c_next;
    logic [DIM_W:0]         ph_reg, pw_reg;
    logic [ADDR_W-1:0]      src_reg, dst_reg;
    deg_e                   q_reg;
    logic                   mirror_eff;

    logic [ADDR_W-1:0]      addr_reg, addr_next;
    logic                   valid_reg, valid_next;
    logic                   write_reg, write_next;
    logic [2*TILE_LOG2-1:0] count_reg, count_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;

    logic                   go;
    logic                   load;
    logic                   beat_done;
    logic                   tile_end;
    logic [TW-1:0]          tx_last, ty_last;
    logic [DIM_W:0]         ph_in, pw_in;
    logic [DIM_W:0]         y_next, x_next;
    logic [DIM_W:0]         dy, dx, dw;
    logic [ADDR_W-1:0]      src_eff;
    logic [ADDR_W-1:0]      rd_addr, wr_addr;

    // Round each dimension up to a whole number of tiles.
    assign ph_in = ({1'b0, I_HEIGHT} + PAD_ADD) & PAD_MASK;
    assign pw_in = ({1'b0, I_WIDTH}  + PAD_ADD) & PAD_MASK;

    assign tx_last   = pw_reg[DIM_W:TILE_LOG2] - 1'b1;
    assign ty_last   = ph_reg[DIM_W:TILE_LOG2] - 1'b1;
    assign beat_done = valid_reg && dma.I_DMA_READY;
    assign tile_end  = (r_reg == T_LAST) && (c_reg == T_LAST);

`ifdef ROT_MIRROR_EN
    logic mirror_reg;
    assign mirror_eff = mirror_reg;

    // Mirror mode is captured with the rest of the job configuration.
    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            mirror_reg <= 1'b0;
        end else if (go) begin
            mirror_reg <= I_MIRROR;
        end
    end
`else
    logic unused_mirror_in;
    assign unused_mirror_in = I_MIRROR;
    assign mirror_eff       = 1'b0;
`endif

    // Next-state, tile/pixel counters and handshake flags.
    always_comb begin
        state_next = state_reg;
        ty_next    = ty_reg;
        tx_next    = tx_reg;
        r_next     = r_reg;
        c_next     = c_reg;
        valid_next = valid_reg;
        write_next = write_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        go         = 1'b0;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                valid_next = 1'b0;
                write_next = 1'b0;
                busy_next  = 1'b0;
                if (I_START) begin
                    go        = 1'b1;
                    busy_next = 1'b1;
                    ty_next   = '0;
                    tx_next   = '0;
                    r_next    = '0;
                    c_next    = '0;
                    if (I_HEIGHT == '0 || I_WIDTH == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = READ;
                        valid_next = 1'b1;
                        load       = 1'b1;
                    end
                end
            end
            READ: begin
                if (beat_done) begin
                    load   = 1'b1;
                    c_next = c_reg + 1'b1;
                    if (c_reg == T_LAST) begin
                        r_next = r_reg + 1'b1;
                    end
                    if (tile_end) begin
                        state_next = WRITE;
                        write_next = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (beat_done) begin
                    c_next = c_reg + 1'b1;
                    if (c_reg == T_LAST) begin
                        r_next = r_reg + 1'b1;
                    end
                    if (!tile_end) begin
                        load = 1'b1;
                    end else if (tx_reg != tx_last) begin
                        tx_next    = tx_reg + 1'b1;
                        state_next = READ;
                        write_next = 1'b0;
                        load       = 1'b1;
                    end else if (ty_reg != ty_last) begin
                        tx_next    = '0;
                        ty_next    = ty_reg + 1'b1;
                        state_next = READ;
                        write_next = 1'b0;
                        load       = 1'b1;
                    end else begin
                        state_next = DONE;
                        valid_next = 1'b0;
                        write_next = 1'b0;
                        done_next  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Source pixel of the beat about to be presented.
    assign y_next  = {ty_next, r_next};
    assign x_next  = {tx_next, c_next};
    assign src_eff = go ? I_SRC_BASE : src_reg;

    rot_coord_map #(
        .DIM_W (DIM_W)
    ) u_coord_map (
        .y      (y_next),
        .x      (x_next),
        .q      (q_reg),
        .mirror (mirror_eff),
        .ph     (ph_reg),
        .pw     (pw_reg),
        .dy     (dy),
        .dx     (dx),
        .dw     (dw)
    );

    assign rd_addr = src_eff
                   + (ADDR_W'(y_next) * ADDR_W'(pw_reg) + ADDR_W'(x_next)) * ADDR_W'(BPP);
    assign wr_addr = dst_reg
                   + (ADDR_W'(dy) * ADDR_W'(dw) + ADDR_W'(dx)) * ADDR_W'(BPP);

    // Beat address and tile-buffer index only change when a new beat is issued.
    always_comb begin
        addr_next  = addr_reg;
        count_next = count_reg;
        if (load) begin
            addr_next  = write_next ? wr_addr : rd_addr;
            count_next = {r_next, c_next};
        end
    end

    // State, counters, captured configuration and registered outputs.
    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state_reg <= IDLE;
            ty_reg    <= '0;
            tx_reg    <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            ph_reg    <= '0;
            pw_reg    <= '0;
            src_reg   <= '0;
            dst_reg   <= '0;
            q_reg     <= DEG_0;
            addr_reg  <= '0;
            valid_reg <= 1'b0;
            write_reg <= 1'b0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ty_reg    <= ty_next;
            tx_reg    <= tx_next;
            r_reg     <= r_next;
            c_reg     <= c_next;
            addr_reg  <= addr_next;
            valid_reg <= valid_next;
            write_reg <= write_next;
            count_reg <= count_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            if (go) begin
                ph_reg  <= ph_in;
                pw_reg  <= pw_in;
                src_reg <= I_SRC_BASE;
                dst_reg <= I_DST_BASE;
                q_reg   <= cw_turns(I_DIRECTION, I_DEGREES);
            end
        end
    end

    assign dma.O_ADDR  = addr_reg;
    assign dma.O_VALID = valid_reg;
    assign dma.O_WRITE = write_reg;
    assign dma.O_COUNT = count_reg;
    assign O_BUSY      = busy_reg;
    assign O_DONE      = done_reg;

endmodule

// File: tb/tb_rot_tile_addr_gen.sv
// Self-checking bench for rot_tile_addr_gen: a reference model pushes the
// expected beat sequence of each job into a scoreboard queue, a monitor
// pops and compares every accepted beat; directed checks cover timing,
// stall, reset, zero-size and mirror behaviour (ROT_MIRROR_EN aware).
module tb_rot_tile_addr_gen;

    localparam int ADDR_W    = 32;
    localparam int DIM_W     = 15;
    localparam int TILE_LOG2 = 3;
    localparam int BPP       = 3;
    localparam int T         = 1 << TILE_LOG2;

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic                   wr;
        logic [2*TILE_LOG2-1:0] cnt;
    } beat_t;

    logic              clk = 1'b0;
    logic              srst;
    logic              start;
    logic [DIM_W-1:0]  height, width;
    logic [ADDR_W-1:0] src_base, dst_base;
    logic              direction;
    logic [1:0]        degrees;
    logic              mirror;
    logic              busy, done;

    beat_t             exp_q[$];
    logic [ADDR_W-1:0] obs_addr[$];
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    rot_tile_addr_gen_if #(.ADDR_W(ADDR_W), .TILE_LOG2(TILE_LOG2)) dma_if ();

    rot_tile_addr_gen #(
        .ADDR_W    (ADDR_W),
        .DIM_W     (DIM_W),
        .TILE_LOG2 (TILE_LOG2),
        .BPP       (BPP)
    ) dut (
        .I_HCLK      (clk),
        .I_HRESET    (srst),
        .I_START     (start),
        .I_HEIGHT    (height),
        .I_WIDTH     (width),
        .I_SRC_BASE  (src_base),
        .I_DST_BASE  (dst_base),
        .I_DIRECTION (direction),
        .I_DEGREES   (degrees),
        .I_MIRROR    (mirror),
        .dma         (dma_if),
        .O_BUSY      (busy),
        .O_DONE      (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected beats of a whole job, in issue order.
    task automatic push_job(input int h, input int w, input logic [ADDR_W-1:0] s,
                            input logic [ADDR_W-1:0] d, input int dir, input int deg,
                            input int mir);
        int ph, pw, q, y, x, xm, dy, dx, dw;
        beat_t b;
        ph = ((h + T - 1) / T) * T;
        pw = ((w + T - 1) / T) * T;
        q  = (dir != 0) ? deg : (4 - deg) % 4;
`ifndef ROT_MIRROR_EN
        mir = 0;
`endif
        if (h == 0 || w == 0) return;
        for (int ty = 0; ty < ph / T; ty++) begin
            for (int tx = 0; tx < pw / T; tx++) begin
                for (int k = 0; k < T * T; k++) begin
                    y = ty * T + k / T;
                    x = tx * T + k % T;
                    b.addr = s + ADDR_W'((y * pw + x) * BPP);
                    b.wr   = 1'b0;
                    b.cnt  = (2*TILE_LOG2)'(k);
                    exp_q.push_back(b);
                end
                for (int k = 0; k < T * T; k++) begin
                    y  = ty * T + k / T;
                    x  = tx * T + k % T;
                    xm = (mir != 0) ? (pw - 1 - x) : x;
                    case (q)
                        1:       begin dy = xm;         dx = ph - 1 - y;  end
                        2:       begin dy = ph - 1 - y; dx = pw - 1 - xm; end
                        3:       begin dy = pw - 1 - xm; dx = y;          end
                        default: begin dy = y;          dx = xm;          end
                    endcase
                    dw     = (q % 2 == 1) ? ph : pw;
                    b.addr = d + ADDR_W'((dy * dw + dx) * BPP);
                    b.wr   = 1'b1;
                    b.cnt  = (2*TILE_LOG2)'(k);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // Scoreboard monitor: every accepted beat is popped and compared.
    always @(negedge clk) begin
        beat_t e;
        beat_t o;
        if (srst === 1'b0 && dma_if.O_VALID === 1'b1 && dma_if.I_DMA_READY === 1'b1) begin
            o.addr = dma_if.O_ADDR;
            o.wr   = dma_if.O_WRITE;
            o.cnt  = dma_if.O_COUNT;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(o), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check($sformatf("beat%0d", obs_addr.size()), 64'(o), 64'(e));
            end
            obs_addr.push_back(o.addr);
        end
    end

    task automatic set_cfg(input int h, input int w, input logic [ADDR_W-1:0] s,
                           input logic [ADDR_W-1:0] d, input int dir, input int deg,
                           input int mir);
        height    = DIM_W'(h);
        width     = DIM_W'(w);
        src_base  = s;
        dst_base  = d;
        direction = 1'(dir);
        degrees   = 2'(deg);
        mirror    = 1'(mir);
    endtask

    // Runs one job; optionally stalls READY for 5 cycles at a read beat.
    task automatic run_job(input string name, input int h, input int w,
                           input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input int dir, input int deg, input int mir, input int stall_at,
                           output int done_cyc, output int nbeats);
        int cyc;
        bit stalled;
        exp_q.delete();
        obs_addr.delete();
        set_cfg(h, w, s, d, dir, deg, mir);
        push_job(h, w, s, d, dir, deg, mir);
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cyc     = 1;
        stalled = 1'b0;
        while (done !== 1'b1 && cyc < 5000) begin
            if (stall_at >= 0 && !stalled && dma_if.O_VALID === 1'b1 && dma_if.O_WRITE === 1'b0
                && dma_if.O_COUNT === (2*TILE_LOG2)'(stall_at)) begin
                stalled = 1'b1;
                dma_if.I_DMA_READY = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    if (i == 2) begin
                        start    = 1'b1;
                        src_base = 32'h00DE_AD00;
                    end
                    @(posedge clk); #1;
                    start = 1'b0;
                    cyc++;
                    check($sformatf("stall_addr%0d", i), 64'(dma_if.O_ADDR),
                          64'(s + ADDR_W'(stall_at * BPP)));
                    check($sformatf("stall_count%0d", i), 64'(dma_if.O_COUNT), 64'(stall_at));
                    check($sformatf("stall_valid%0d", i), 64'(dma_if.O_VALID), 64'(1));
                end
                src_base = s;
                dma_if.I_DMA_READY = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        done_cyc = (done === 1'b1) ? cyc : -1;
        nbeats   = obs_addr.size();
        check({name, "_done_seen"}, 64'(done), 64'(1));
        check({name, "_done_valid_low"}, 64'(dma_if.O_VALID), 64'(0));
        check({name, "_done_busy"}, 64'(busy), 64'(1));
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 64'(done), 64'(0));
        check({name, "_idle_busy"}, 64'(busy), 64'(0));
        $display("[TB] job %s %0dx%0d dir=%0d deg=%0d mir=%0d beats=%0d done_cycle=%0d",
                 name, h, w, dir, deg, mir, nbeats, done_cyc);
    endtask

    initial begin
        int dc, nb, cyc;
        logic [ADDR_W-1:0] mir_exp;

        srst  = 1'b1;
        start = 1'b0;
        dma_if.I_DMA_READY = 1'b1;
        set_cfg(0, 0, 0, 0, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr",  64'(dma_if.O_ADDR),  64'(0));
        check("rst_valid", 64'(dma_if.O_VALID), 64'(0));
        check("rst_write", 64'(dma_if.O_WRITE), 64'(0));
        check("rst_count", 64'(dma_if.O_COUNT), 64'(0));
        check("rst_busy",  64'(busy),           64'(0));
        check("rst_done",  64'(done),           64'(0));
        srst = 1'b0;
        @(posedge clk); #1;

        // 8x8, no rotation
        run_job("q0_8x8", 8, 8, 32'h0, 32'h1000, 1, 0, 0, -1, dc, nb);
        check("q0_done_cycle", 64'(dc), 64'(129));
        check("q0_beats", 64'(nb), 64'(128));
        check("q0_read1", 64'(obs_addr[1]), 64'h3);
        check("q0_read_last", 64'(obs_addr[63]), 64'hBD);
        check("q0_write_first", 64'(obs_addr[64]), 64'h1000);
        check("q0_write_last", 64'(obs_addr[127]), 64'h10BD);

        // 8x16, clockwise 90
        run_job("cw90_8x16", 8, 16, 32'h0, 32'h0, 1, 1, 0, -1, dc, nb);
        check("cw90_beats", 64'(nb), 64'(256));
        check("cw90_done_cycle", 64'(dc), 64'(257));
        check("cw90_src00", 64'(obs_addr[64]), 64'h15);
        check("cw90_src0_15", 64'(obs_addr[199]), 64'h17D);

        // 5x10 padded to 8x16, clockwise 180
        run_job("cw180_5x10", 5, 10, 32'h2000, 32'h8000, 1, 2, 0, -1, dc, nb);
        check("cw180_beats", 64'(nb), 64'(256));
        check("cw180_src7_15", 64'(obs_addr[255]), 64'h8000);
        check("cw180_src00", 64'(obs_addr[64]), 64'h817D);

        // Counter-clockwise 90 equals clockwise 270
        run_job("ccw90_8x8", 8, 8, 32'h0, 32'h4000, 0, 1, 0, -1, dc, nb);
        check("ccw90_src00", 64'(obs_addr[64]), 64'h40A8);

        // READY stall at read beat 10 with an ignored start pulse
        run_job("stall_8x8", 8, 8, 32'h100, 32'h1000, 1, 0, 0, 10, dc, nb);
        check("stall_done_cycle", 64'(dc), 64'(134));
        check("stall_beats", 64'(nb), 64'(128));

        // Mirror (only effective with ROT_MIRROR_EN)
`ifdef ROT_MIRROR_EN
        mir_exp = 32'h1015;
`else
        mir_exp = 32'h1000;
`endif
        run_job("mirror_8x8", 8, 8, 32'h0, 32'h1000, 1, 0, 1, -1, dc, nb);
        check("mirror_src00", 64'(obs_addr[64]), 64'(mir_exp));

        // Reset in the middle of a write phase
        exp_q.delete();
        obs_addr.delete();
        set_cfg(8, 8, 32'h0, 32'h1000, 1, 0, 0);
        push_job(8, 8, 32'h0, 32'h1000, 1, 0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (dma_if.O_WRITE !== 1'b1 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rstw_reached_write", 64'(dma_if.O_WRITE), 64'(1));
        repeat (3) begin @(posedge clk); #1; end
        srst = 1'b1;
        @(posedge clk); #1;
        check("rstw_valid", 64'(dma_if.O_VALID), 64'(0));
        check("rstw_addr",  64'(dma_if.O_ADDR),  64'(0));
        check("rstw_write", 64'(dma_if.O_WRITE), 64'(0));
        check("rstw_count", 64'(dma_if.O_COUNT), 64'(0));
        check("rstw_busy",  64'(busy),           64'(0));
        srst = 1'b0;
        exp_q.delete();
        $display("[TB] job reset_mid_write abandoned after %0d observed beats", obs_addr.size());
        @(posedge clk); #1;

        // Zero width: straight to DONE with no beats
        run_job("zero_w", 8, 0, 32'h0, 32'h0, 1, 0, 0, -1, dc, nb);
        check("zero_done_cycle", 64'(dc), 64'(1));
        check("zero_beats", 64'(nb), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rot_tile_addr_gen.md
# rot_tile_addr_gen

Parametrised tile address generator for the image-rotation core. It walks a source image in square pixel tiles and issues one read beat per pixel, then one write beat per pixel to the rotated and optionally mirrored destination location. It sits between the register block, which supplies geometry and mode, and the DMA master, which performs the transfers. Tile size, pixel size and address width are parameters. Compared with the previous generation it adds base addresses, a DMA valid/ready handshake, a done pulse, and mode capture at start.

## Interface
- ADDR_W, 32, address width
- DIM_W, 15, width of height/width inputs in pixels
- TILE_LOG2, 3, log2 of tile edge T (default T=8)
- BPP, 3, bytes per pixel
- I_HCLK  in  1  clock
- I_HRESET  in  1  synchronous reset, active-high
- I_START  in  1  start pulse, sampled only in IDLE
- I_HEIGHT  in  DIM_W  source height H, pixels
- I_WIDTH  in  DIM_W  source width W, pixels
- I_SRC_BASE  in  ADDR_W  source byte base address
- I_DST_BASE  in  ADDR_W  destination byte base address
- I_DIRECTION  in  1  1 = clockwise, 0 = counter-clockwise
- I_DEGREES  in  2  number of quarter turns, 0..3
- I_MIRROR  in  1  flip horizontally before rotating
- I_DMA_READY  in  1  DMA accepts the current beat
- O_ADDR  out  ADDR_W  beat byte address
- O_VALID  out  1  beat valid
- O_WRITE  out  1  0 = read beat, 1 = write beat
- O_COUNT  out  2*TILE_LOG2  beat index within tile; equals the tile-buffer index
- O_BUSY  out  1  job in progress
- O_DONE  out  1  one-cycle end-of-job pulse

## Operation
- States: IDLE, READ, WRITE, DONE.
- In IDLE, I_START captures all I_* configuration into registers. Inputs are ignored for the rest of the job.
- Padding: PH = ceil(H/T)*T and PW = ceil(W/T)*T, each DIM_W+1 bits.
- Zero dimension: if H=0 or W=0, the block goes IDLE→DONE with no beats.
- Otherwise IDLE→READ.
- Tile order is raster over the source: tile row ty outer, tile column tx inner.
- Within a tile, beat k = r*T + c, with r outer and c inner, k = 0..T²-1.
- READ beat address: SRC_BASE + ((ty*T+r)*PW + tx*T+c)*BPP.
- After the last READ beat is accepted, go to WRITE for the same tile, using the same k order.
- WRITE mapping for source pixel (y,x), evaluated in this order:
  - Mirror: x = PW-1-x, when mirroring is enabled.
  - Clockwise turns: q = I_DIRECTION ? I_DEGREES : (4-I_DEGREES) mod 4.
  - q=0: (y,x). q=1: (x, PH-1-y). q=2: (PH-1-y, PW-1-x). q=3: (PW-1-x, y).
- Destination width: DW = PW for q even, PH for q odd.
- WRITE beat address: DST_BASE + (dy*DW+dx)*BPP.
- After the last WRITE beat is accepted: go to READ of the next tile, or to DONE if this was the last tile.
- DONE lasts one cycle (O_DONE=1), then returns to IDLE.
- All address arithmetic is modulo 2^ADDR_W. Overflow is not detected; software keeps images within range.
- Padded pixels are transferred like real pixels.

## Timing
- Reset values: O_ADDR=0, O_VALID=0, O_WRITE=0, O_COUNT=0, O_BUSY=0, O_DONE=0; state IDLE.
- All outputs are registered.
- I_START sampled at edge N → O_VALID and O_BUSY high from edge N+1, carrying READ beat 0.
- A beat completes on a cycle where O_VALID && I_DMA_READY. The next beat's address is presented on the following cycle, with no bubble.
- While I_DMA_READY is low, O_ADDR, O_WRITE and O_COUNT hold.
- READ→WRITE and tile→tile transitions insert no idle cycle.
- O_BUSY is high in READ, WRITE and DONE. O_VALID is low in DONE.
- I_START while busy is ignored.
- I_HRESET at any point: outputs take their reset values on the next edge; the job is abandoned.
- Total beats per job: 2*PH*PW. With READY held high, O_DONE asserts 2*PH*PW+1 cycles after the start edge.

## Configuration
- ROT_MIRROR_EN defined: I_MIRROR is captured at start and applied as specified.
- ROT_MIRROR_EN undefined: I_MIRROR is ignored, treated as 0; no mirror logic is built.

## Structure
- Package rot_pkg holds:
  - the state enum;
  - the quarter-turn encodings DEG_0/90/180/270;
  - a function computing effective clockwise turns from direction and degrees.
- Sub-module rot_coord_map: combinational mapping from (y, x, q, mirror, PH, PW) to (dy, dx, DW).
- Counters and the FSM stay in the top module.

## Test plan
- 8x8, q=0, SRC=0x0, DST=0x1000, READY=1:
  - 128 beats; reads 0x0, 0x3 … 0xBD; writes 0x1000 … 0x10BD in the same order.
  - O_DONE at cycle 129 after the start edge.
- H=8, W=16, CW 90, DST=0:
  - Write of source (0,0) → 0x15.
  - Source (0,15) → (15,7) → 0x17D.
  - 256 beats.
- H=5, W=10, CW 180:
  - Padded to 8x16; 256 beats.
  - Source (7,15) writes to DST+0; source (0,0) writes to DST+0x17D.
- DIRECTION=0, DEGREES=1 on 8x8: source (0,0) → (7,0) → DST+0xA8, matching CW 270.
- Drop READY for 5 cycles at READ beat 10: O_ADDR and O_COUNT=10 hold; an I_START pulse during the stall is ignored.
- Reset asserted mid-WRITE: IDLE with O_VALID=0, O_ADDR=0 next cycle. A W=0 start gives O_DONE at cycle 1 with no valid beats.
- ROT_MIRROR_EN, 8x8, q=0, MIRROR=1: source (0,0) → DST+0x15. Without the macro, the same stimulus → DST+0.
